dmem_arbiter: RTL and testbench

- Two-master arbiter sharing one single-port data memory (BSRAM or synthesized) between the core load/store port (m0) and the debug/boot-loader port (m1).
- Issues at most one access per cycle and grants round-robin under contention.
- Tracks in-flight reads through a tag pipeline so read data returns to the correct master after the memory's fixed read latency.
- Sits between the core/loader and the dmem instance.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_arbiter_rd_tag_pipe.sv | 44 ++++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// Optional statistics counters are enabled with DMEM_ARB_STATS_EN.
package dmem_pkg;

  localparam int M_CORE   = 0;
  localparam int M_LOADER = 1;

  localparam int DMEM_ADDR_W = 11;
  localparam int DMEM_DATA_W = 32;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  // Saturating 16-bit increment used by the statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags with synchronous clear.
// RD_LAT = 0 collapses to a combinational bypass.
module rd_tag_pipe
  import dmem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    clr,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  generate
    if (RD_LAT == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = clk ^ clr;
      assign tag_out   = tag_in;
    end else begin : g_pipe
      rd_tag_t pipe_q [RD_LAT];
      rd_tag_t pipe_d [RD_LAT];

      always_comb begin
        pipe_d[0] = tag_in;
        for (int i = 1; i < RD_LAT; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (clr) begin
          for (int i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign tag_out = pipe_q[RD_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between core (m0) and loader (m1).
// Define DMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_acc0,
  output logic [15:0]       stat_acc1,
  output logic [15:0]       stat_conflict
`endif
);

  logic              ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              both, gnt0, gnt1, issue, we_mux, rvalid0, rvalid1;
  rd_tag_t           tag_in, tag_out;

  // ptr_q = 0 favours the core; reset masks grants and any tag still in flight.
  always_comb begin
    both    = m0_req & m1_req;
    gnt0    = ~reset & m0_req & (~m1_req | ~ptr_q);
    gnt1    = ~reset & m1_req & (~m0_req | ptr_q);
    issue   = gnt0 | gnt1;
    ptr_d   = both ? ~ptr_q : ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_mux  = 1'b0;
    if (gnt1) begin
      addr_d  = m1_addr;
      wdata_d = m1_wdata;
      we_mux  = m1_we;
    end else if (gnt0) begin
      addr_d  = m0_addr;
      wdata_d = m0_wdata;
      we_mux  = m0_we;
    end
    tag_in.valid = issue & ~we_mux;
    tag_in.id    = gnt1 ? 1'(M_LOADER) : 1'(M_CORE);
    rvalid0      = ~reset & tag_out.valid & (tag_out.id == 1'(M_CORE));
    rvalid1      = ~reset & tag_out.valid & (tag_out.id == 1'(M_LOADER));
    rdata0_d     = rvalid0 ? mem_rdata : rdata0_q;
    rdata1_d     = rvalid1 ? mem_rdata : rdata1_q;
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_rd_tag_pipe (
    .clk    (clk),
    .clr    (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rvalid0;
  assign m1_rvalid = rvalid1;
  assign m0_rdata  = rdata0_d;
  assign m1_rdata  = rdata1_d;
  assign mem_ce    = issue;
  assign mem_we    = we_mux;
  assign mem_addr  = addr_d;
  assign mem_wdata = wdata_d;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] acc0_q, acc0_d, acc1_q, acc1_d, conflict_q, conflict_d;

  always_comb begin
    acc0_d     = gnt0 ? sat_inc(acc0_q) : acc0_q;
    acc1_d     = gnt1 ? sat_inc(acc1_q) : acc1_q;
    conflict_d = both ? sat_inc(conflict_q) : conflict_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc0_q     <= '0;
      acc1_q     <= '0;
      conflict_q <= '0;
    end else begin
      acc0_q     <= acc0_d;
      acc1_q     <= acc1_d;
      conflict_q <= conflict_d;
    end
  end

  assign stat_acc0     = acc0_q;
  assign stat_acc1     = acc1_q;
  assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (RD_LAT = 1) with a write-first registered memory model.
// Stats checks are compiled in when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [10:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_ce, mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [2048];
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_acc0, stat_acc1, stat_conflict;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_gnt   (m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_gnt   (m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata (m1_rdata),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_acc0    (stat_acc0),
    .stat_acc1    (stat_acc1),
    .stat_conflict(stat_conflict)
`endif
  );

  // Registered, write-first single-port memory.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct packed {
    logic        r0;
    logic        w0;
    logic [10:0] a0;
    logic [31:0] d0;
    logic        r1;
    logic        w1;
    logic [10:0] a1;
    logic [31:0] d1;
    logic        g0;
    logic        g1;
    logic        ce;
    logic        we;
    logic [10:0] ea;
    logic [31:0] ed;
    logic        v0;
    logic        v1;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  task automatic checkVal(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic setInputs(input logic r0, input logic w0, input logic [10:0] a0, input logic [31:0] d0,
                           input logic r1, input logic w1, input logic [10:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic applyStimulus(input vec_t v);
    setInputs(v.r0, v.w0, v.a0, v.d0, v.r1, v.w1, v.a1, v.d1);
  endtask

  task automatic checkOutput(input vec_t v, input int row);
    @(negedge clk);
    checkVal("m0_gnt",    row, 32'(m0_gnt),    32'(v.g0));
    checkVal("m1_gnt",    row, 32'(m1_gnt),    32'(v.g1));
    checkVal("mem_ce",    row, 32'(mem_ce),    32'(v.ce));
    checkVal("mem_we",    row, 32'(mem_we),    32'(v.we));
    checkVal("mem_addr",  row, 32'(mem_addr),  32'(v.ea));
    checkVal("mem_wdata", row, mem_wdata,      v.ed);
    checkVal("m0_rvalid", row, 32'(m0_rvalid), 32'(v.v0));
    checkVal("m1_rvalid", row, 32'(m1_rvalid), 32'(v.v1));
    checkVal("m0_rdata",  row, m0_rdata,       v.rd0);
    checkVal("m1_rdata",  row, m1_rdata,       v.rd1);
    @(posedge clk);
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fields: m0 req/we/addr/wdata, m1 req/we/addr/wdata | gnt0 gnt1 ce we addr wdata | rv0 rv1 rdata0 rdata1
    vecs[0]  = '{1'b1,1'b1,11'd0,32'h7,  1'b0,1'b0,11'd0,32'h0,  1'b1,1'b0,1'b1,1'b1,11'd0,32'h7,  1'b0,1'b0,32'h0,32'h0};
    vecs[1]  = '{1'b1,1'b0,11'd0,32'h0,  1'b0,1'b0,11'd0,32'h0,  1'b1,1'b0,1'b1,1'b0,11'd0,32'h0,  1'b0,1'b0,32'h0,32'h0};
    vecs[2]  = '{1'b0,1'b0,11'd0,32'h0,  1'b0,1'b0,11'd0,32'h0,  1'b0,1'b0,1'b0,1'b0,11'd0,32'h0,  1'b1,1'b0,32'h7,32'h0};
    vecs[3]  = '{1'b0,1'b0,11'd0,32'h0,  1'b1,1'b1,11'd1,32'h11, 1'b0,1'b1,1'b1,1'b1,11'd1,32'h11, 1'b0,1'b0,32'h7,32'h0};
    vecs[4]  = '{1'b0,1'b0,11'd0,32'h0,  1'b1,1'b1,11'd2,32'h22, 1'b0,1'b1,1'b1,1'b1,11'd2,32'h22, 1'b0,1'b0,32'h7,32'h0};
    vecs[5]  = '{1'b1,1'b1,11'd4,32'h40, 1'b0,1'b0,11'd0,32'h0,  1'b1,1'b0,1'b1,1'b1,11'd4,32'h40, 1'b0,1'b0,32'h7,32'h0};
    vecs[6]  = '{1'b1,1'b1,11'd5,32'h41, 1'b0,1'b0,11'd0,32'h0,  1'b1,1'b0,1'b1,1'b1,11'd5,32'h41, 1'b0,1'b0,32'h7,32'h0};
    vecs[7]  = '{1'b1,1'b1,11'd6,32'h42, 1'b0,1'b0,11'd0,32'h0,  1'b1,1'b0,1'b1,1'b1,11'd6,32'h42, 1'b0,1'b0,32'h7,32'h0};
    vecs[8]  = '{1'b1,1'b1,11'd7,32'h43, 1'b0,1'b0,11'd0,32'h0,  1'b1,1'b0,1'b1,1'b1,11'd7,32'h43, 1'b0,1'b0,32'h7,32'h0};
    vecs[9]  = '{1'b1,1'b0,11'd1,32'h0,  1'b1,1'b0,11'd2,32'h0,  1'b1,1'b0,1'b1,1'b0,11'd1,32'h0,  1'b0,1'b0,32'h7,32'h0};
    vecs[10] = '{1'b1,1'b0,11'd1,32'h0,  1'b1,1'b0,11'd2,32'h0,  1'b0,1'b1,1'b1,1'b0,11'd2,32'h0,  1'b1,1'b0,32'h11,32'h0};
    vecs[11] = '{1'b1,1'b0,11'd1,32'h0,  1'b1,1'b0,11'd2,32'h0,  1'b1,1'b0,1'b1,1'b0,11'd1,32'h0,  1'b0,1'b1,32'h11,32'h22};
    vecs[12] = '{1'b1,1'b0,11'd1,32'h0,  1'b1,1'b0,11'd2,32'h0,  1'b0,1'b1,1'b1,1'b0,11'd2,32'h0,  1'b1,1'b0,32'h11,32'h22};
    vecs[13] = '{1'b0,1'b0,11'd0,32'h0,  1'b1,1'b0,11'd4,32'h0,  1'b0,1'b1,1'b1,1'b0,11'd4,32'h0,  1'b0,1'b1,32'h11,32'h22};
    vecs[14] = '{1'b0,1'b0,11'd0,32'h0,  1'b1,1'b0,11'd5,32'h0,  1'b0,1'b1,1'b1,1'b0,11'd5,32'h0,  1'b0,1'b1,32'h11,32'h40};
    vecs[15] = '{1'b0,1'b0,11'd0,32'h0,  1'b1,1'b0,11'd6,32'h0,  1'b0,1'b1,1'b1,1'b0,11'd6,32'h0,  1'b0,1'b1,32'h11,32'h41};
    vecs[16] = '{1'b0,1'b0,11'd0,32'h0,  1'b1,1'b0,11'd7,32'h0,  1'b0,1'b1,1'b1,1'b0,11'd7,32'h0,  1'b0,1'b1,32'h11,32'h42};
    vecs[17] = '{1'b0,1'b0,11'd0,32'h0,  1'b0,1'b0,11'd0,32'h0,  1'b0,1'b0,1'b0,1'b0,11'd7,32'h0,  1'b0,1'b1,32'h11,32'h43};
    vecs[18] = '{1'b1,1'b0,11'd1,32'h0,  1'b1,1'b0,11'd2,32'h0,  1'b1,1'b0,1'b1,1'b0,11'd1,32'h0,  1'b0,1'b0,32'h11,32'h43};
    vecs[19] = '{1'b0,1'b0,11'd0,32'h0,  1'b0,1'b0,11'd0,32'h0,  1'b0,1'b0,1'b0,1'b0,11'd1,32'h0,  1'b1,1'b0,32'h11,32'h43};
    vecs[20] = '{1'b1,1'b1,11'd4,32'h19, 1'b0,1'b0,11'd0,32'h0,  1'b1,1'b0,1'b1,1'b1,11'd4,32'h19, 1'b0,1'b0,32'h11,32'h43};
    vecs[21] = '{1'b0,1'b0,11'd0,32'h0,  1'b1,1'b0,11'd4,32'h0,  1'b0,1'b1,1'b1,1'b0,11'd4,32'h0,  1'b0,1'b0,32'h11,32'h43};
    vecs[22] = '{1'b0,1'b0,11'd0,32'h0,  1'b0,1'b0,11'd0,32'h0,  1'b0,1'b0,1'b0,1'b0,11'd4,32'h0,  1'b0,1'b1,32'h11,32'h19};
    vecs[23] = '{1'b0,1'b1,11'd9,32'h99, 1'b0,1'b0,11'd0,32'h0,  1'b0,1'b0,1'b0,1'b0,11'd4,32'h0,  1'b0,1'b0,32'h11,32'h19};
    vecs[24] = '{1'b1,1'b0,11'd1,32'h0,  1'b1,1'b0,11'd2,32'h0,  1'b0,1'b1,1'b1,1'b0,11'd2,32'h0,  1'b0,1'b0,32'h11,32'h19};
    vecs[25] = '{1'b0,1'b0,11'd0,32'h0,  1'b0,1'b0,11'd0,32'h0,  1'b0,1'b0,1'b0,1'b0,11'd2,32'h0,  1'b0,1'b1,32'h11,32'h22};

    // Reset with a pending request: grants and strobes must stay low.
    reset = 1'b1;
    setInputs(1'b1, 1'b0, 11'd0, 32'h0, 1'b0, 1'b0, 11'd0, 32'h0);
    nextCycle();
    @(negedge clk);
    checkVal("reset_m0_gnt",    -1, 32'(m0_gnt),    32'h0);
    checkVal("reset_mem_ce",    -1, 32'(mem_ce),    32'h0);
    checkVal("reset_mem_we",    -1, 32'(mem_we),    32'h0);
    checkVal("reset_m0_rvalid", -1, 32'(m0_rvalid), 32'h0);
    checkVal("reset_m1_rvalid", -1, 32'(m1_rvalid), 32'h0);
    checkVal("reset_m0_rdata",  -1, m0_rdata,       32'h0);
    checkVal("reset_m1_rdata",  -1, m1_rdata,       32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Contended read won by m0 (pointer moves to m1), then reset while the tag is in flight.
    setInputs(1'b1, 1'b0, 11'd1, 32'h0, 1'b1, 1'b0, 11'd2, 32'h0);
    @(negedge clk);
    checkVal("midrst_grant_m0", 100, 32'(m0_gnt), 32'h1);
    checkVal("midrst_grant_m1", 100, 32'(m1_gnt), 32'h0);
    nextCycle();
    reset = 1'b1;
    setInputs(1'b0, 1'b0, 11'd0, 32'h0, 1'b0, 1'b0, 11'd0, 32'h0);
    @(negedge clk);
    checkVal("midrst_no_rvalid0", 101, 32'(m0_rvalid), 32'h0);
    nextCycle();
    setInputs(1'b0, 1'b0, 11'd0, 32'h0, 1'b1, 1'b0, 11'd2, 32'h0);
    @(negedge clk);
    checkVal("midrst_m0_gnt",    102, 32'(m0_gnt),    32'h0);
    checkVal("midrst_m1_gnt",    102, 32'(m1_gnt),    32'h0);
    checkVal("midrst_m0_rvalid", 102, 32'(m0_rvalid), 32'h0);
    checkVal("midrst_m1_rvalid", 102, 32'(m1_rvalid), 32'h0);
    checkVal("midrst_m0_rdata",  102, m0_rdata,       32'h0);
    checkVal("midrst_m1_rdata",  102, m1_rdata,       32'h0);
    checkVal("midrst_mem_ce",    102, 32'(mem_ce),    32'h0);
    checkVal("midrst_mem_we",    102, 32'(mem_we),    32'h0);
    nextCycle();
    reset = 1'b0;
    setInputs(1'b0, 1'b0, 11'd0, 32'h0, 1'b0, 1'b0, 11'd0, 32'h0);
    @(negedge clk);
    checkVal("postrst_rvalid0", 103, 32'(m0_rvalid), 32'h0);
    checkVal("postrst_rvalid1", 103, 32'(m1_rvalid), 32'h0);
    nextCycle();
    setInputs(1'b1, 1'b0, 11'd1, 32'h0, 1'b1, 1'b0, 11'd2, 32'h0);
    @(negedge clk);
    checkVal("postrst_ptr_m0", 104, 32'(m0_gnt), 32'h1);
    checkVal("postrst_ptr_m1", 104, 32'(m1_gnt), 32'h0);
    nextCycle();
    setInputs(1'b0, 1'b0, 11'd0, 32'h0, 1'b0, 1'b0, 11'd0, 32'h0);
    @(negedge clk);
    checkVal("postrst_rvalid0_back", 105, 32'(m0_rvalid), 32'h1);
    checkVal("postrst_rdata0",       105, m0_rdata,       32'h11);
    nextCycle();

`ifdef DMEM_ARB_STATS_EN
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    setInputs(1'b1, 1'b0, 11'd1, 32'h0, 1'b1, 1'b0, 11'd2, 32'h0);
    for (int i = 0; i < 10; i++) begin
      nextCycle();
    end
    setInputs(1'b0, 1'b0, 11'd0, 32'h0, 1'b0, 1'b0, 11'd0, 32'h0);
    @(negedge clk);
    checkVal("stat_conflict", 200, 32'(stat_conflict), 32'd10);
    checkVal("stat_acc0",     200, 32'(stat_acc0),     32'd5);
    checkVal("stat_acc1",     200, 32'(stat_acc1),     32'd5);
    nextCycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
